// File: rtl/datapath_if.sv
// Control and observation bundle between the processor controller and its
// execution datapath.
interface datapath_if #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8,
  parameter int RF_AW   = 4
);
  logic [DMEM_AW-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RF_AW-1:0]   RF_W_addr;
  logic               RF_W_en;
  logic [RF_AW-1:0]   RF_Ra_addr;
  logic [RF_AW-1:0]   RF_Rb_addr;
  logic [2:0]         Alu_s0;
  logic [DATA_W-1:0]  Ra_data;
  logic [DATA_W-1:0]  Rb_data;
  logic [DATA_W-1:0]  ALU_out;
  logic [DATA_W-1:0]  Mem_q;
  logic [DATA_W-1:0]  W_data;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    input  Ra_data, Rb_data, ALU_out, Mem_q, W_data
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    output Ra_data, Rb_data, ALU_out, Mem_q, W_data
  );
endinterface

// File: rtl/datapath.sv
// Execution datapath: 256x16 synchronous data memory, 16x16 register file
// with two combinational read ports, and an eight-function 16-bit ALU.
module datapath #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8,
  parameter int RF_AW   = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  datapath_if.slave  bus
);
  localparam int RF_DEPTH   = 1 << RF_AW;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  logic [DATA_W-1:0] regs_r    [RF_DEPTH];
  logic [DATA_W-1:0] mem_r     [DMEM_DEPTH];
  logic [DATA_W-1:0] mem_q_r;
  logic [DATA_W-1:0] ra_s;
  logic [DATA_W-1:0] rb_s;
  logic [DATA_W-1:0] alu_s;
  logic [DATA_W-1:0] w_data_s;

  // No bypass: a same-cycle write is only visible after the edge.
  assign ra_s = regs_r[bus.RF_Ra_addr];
  assign rb_s = regs_r[bus.RF_Rb_addr];

  // ALU function decode, all results wrap modulo 2^DATA_W.
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (bus.Alu_s0)
      3'b000:  alu_s = {DATA_W{1'b0}};
      3'b001:  alu_s = ra_s + rb_s;
      3'b010:  alu_s = ra_s - rb_s;
      3'b011:  alu_s = ra_s;
      3'b100:  alu_s = ra_s ^ rb_s;
      3'b101:  alu_s = ra_s | rb_s;
      3'b110:  alu_s = ra_s & rb_s;
      3'b111:  alu_s = ra_s + {{(DATA_W-1){1'b0}}, 1'b1};
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Register write source select.
  always_comb begin
    w_data_s = alu_s;
    if (bus.RF_s) begin
      w_data_s = mem_q_r;
    end else begin
      w_data_s = alu_s;
    end
  end

  // Register file write port; reset clears every register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.RF_W_en) begin
      regs_r[bus.RF_W_addr] <= w_data_s;
    end
  end

  // Memory array is never cleared; writes are blocked while reset is held.
  always_ff @(posedge Clk) begin
    if (Rst && bus.D_wr) begin
      mem_r[bus.D_addr] <= ra_s;
    end
  end

  // Registered read port returns the pre-write contents on a collision.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem_q_r <= {DATA_W{1'b0}};
    end else begin
      mem_q_r <= mem_r[bus.D_addr];
    end
  end

  assign bus.Ra_data = ra_s;
  assign bus.Rb_data = rb_s;
  assign bus.ALU_out = alu_s;
  assign bus.Mem_q   = mem_q_r;
  assign bus.W_data  = w_data_s;
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the processor datapath.
module tb_datapath;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  datapath_if bus ();

  datapath dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_controls();
    bus.D_addr     = 8'h00;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = 4'd0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = 4'd0;
    bus.RF_Rb_addr = 4'd0;
    bus.Alu_s0     = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_controls();
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) begin
      bus.RF_Ra_addr = i[3:0];
      bus.RF_Rb_addr = 4'(15 - i);
      #1;
      n_checks++;
      if (bus.Ra_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_ra[%0d] got %h want 0000", i, bus.Ra_data);
      end
      n_checks++;
      if (bus.Rb_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_rb[%0d] got %h want 0000", 15 - i, bus.Rb_data);
      end
    end
    n_checks++;
    if (bus.Mem_q !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_memq got %h want 0000", bus.Mem_q);
    end
    bus.Alu_s0 = 3'b111;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0001 || bus.W_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_alu got %h/%h want 0001/0001", bus.ALU_out, bus.W_data);
    end
    idle_controls();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_alu();
    bus.Alu_s0 = 3'b111; bus.RF_Ra_addr = 4'd0; bus.RF_W_addr = 4'd1; bus.RF_W_en = 1'b1;
    step();
    bus.RF_Ra_addr = 4'd1; bus.RF_W_addr = 4'd2;
    step();
    bus.Alu_s0 = 3'b001; bus.RF_Ra_addr = 4'd1; bus.RF_Rb_addr = 4'd2; bus.RF_W_addr = 4'd3;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0003) begin
      n_fail++;
      $display("FAIL alu_add got %h want 0003", bus.ALU_out);
    end
    step();
    bus.RF_W_en = 1'b0;
    bus.RF_Ra_addr = 4'd1; bus.RF_Rb_addr = 4'd2;
    #1;
    n_checks++;
    if (bus.Ra_data !== 16'h0001 || bus.Rb_data !== 16'h0002) begin
      n_fail++;
      $display("FAIL rf_r1_r2 got %h/%h want 0001/0002", bus.Ra_data, bus.Rb_data);
    end
    bus.Alu_s0 = 3'b010; bus.RF_Rb_addr = 4'd3;
    #1;
    n_checks++;
    if (bus.Rb_data !== 16'h0003 || bus.ALU_out !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL alu_sub_wrap got r3=%h alu=%h want 0003/fffe", bus.Rb_data, bus.ALU_out);
    end
    bus.RF_Ra_addr = 4'd2; bus.RF_Rb_addr = 4'd3;
    bus.Alu_s0 = 3'b100;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL alu_xor got %h want 0001", bus.ALU_out);
    end
    bus.Alu_s0 = 3'b101;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0003) begin
      n_fail++;
      $display("FAIL alu_or got %h want 0003", bus.ALU_out);
    end
    bus.Alu_s0 = 3'b110;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0002) begin
      n_fail++;
      $display("FAIL alu_and got %h want 0002", bus.ALU_out);
    end
    bus.Alu_s0 = 3'b011;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0002 || bus.W_data !== 16'h0002) begin
      n_fail++;
      $display("FAIL alu_passa got %h/%h want 0002/0002", bus.ALU_out, bus.W_data);
    end
    bus.Alu_s0 = 3'b000;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL alu_zero got %h want 0000", bus.ALU_out);
    end
    idle_controls();
  endtask

  task automatic test_store_load();
    bus.D_addr = 8'h80; bus.RF_Ra_addr = 4'd3; bus.D_wr = 1'b1;
    step();
    bus.D_wr = 1'b0;
    step();
    n_checks++;
    if (bus.Mem_q !== 16'h0003) begin
      n_fail++;
      $display("FAIL store_memq got %h want 0003", bus.Mem_q);
    end
    bus.RF_s = 1'b1; bus.RF_W_addr = 4'd4; bus.RF_W_en = 1'b1;
    #1;
    n_checks++;
    if (bus.W_data !== 16'h0003) begin
      n_fail++;
      $display("FAIL load_wdata got %h want 0003", bus.W_data);
    end
    step();
    idle_controls();
    bus.RF_Ra_addr = 4'd4;
    #1;
    n_checks++;
    if (bus.Ra_data !== 16'h0003) begin
      n_fail++;
      $display("FAIL load_r4 got %h want 0003", bus.Ra_data);
    end
  endtask

  task automatic test_mem_rdw();
    bus.D_addr = 8'h80; bus.D_wr = 1'b1; bus.RF_Ra_addr = 4'd2;
    step();
    bus.D_wr = 1'b0;
    n_checks++;
    if (bus.Mem_q !== 16'h0003) begin
      n_fail++;
      $display("FAIL mem_rdw_old got %h want 0003", bus.Mem_q);
    end
    step();
    n_checks++;
    if (bus.Mem_q !== 16'h0002) begin
      n_fail++;
      $display("FAIL mem_rdw_new got %h want 0002", bus.Mem_q);
    end
    idle_controls();
  endtask

  task automatic test_rf_rdw();
    bus.RF_W_addr = 4'd5; bus.RF_W_en = 1'b1; bus.Alu_s0 = 3'b111; bus.RF_Ra_addr = 4'd5;
    #1;
    n_checks++;
    if (bus.ALU_out !== 16'h0001 || bus.Ra_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL rf_rdw_old got alu=%h ra=%h want 0001/0000", bus.ALU_out, bus.Ra_data);
    end
    step();
    bus.RF_W_en = 1'b0;
    #1;
    n_checks++;
    if (bus.Ra_data !== 16'h0001 || bus.ALU_out !== 16'h0002) begin
      n_fail++;
      $display("FAIL rf_rdw_new got ra=%h alu=%h want 0001/0002", bus.Ra_data, bus.ALU_out);
    end
    idle_controls();
  endtask

  task automatic test_reset_mid();
    // R5=1 would land in M[0x80] and R6 would get 2 if reset did not block them.
    bus.D_addr = 8'h80; bus.D_wr = 1'b1; bus.RF_Ra_addr = 4'd5;
    bus.Alu_s0 = 3'b111; bus.RF_W_addr = 4'd6; bus.RF_W_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.Ra_data !== 16'h0000 || bus.Mem_q !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_async got ra=%h memq=%h want 0000/0000", bus.Ra_data, bus.Mem_q);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      bus.RF_Ra_addr = i[3:0];
      #1;
      n_checks++;
      if (bus.Ra_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL mid_reset_r[%0d] got %h want 0000", i, bus.Ra_data);
      end
    end
    idle_controls();
    bus.D_addr = 8'h80;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.Mem_q !== 16'h0002) begin
      n_fail++;
      $display("FAIL mid_reset_mem_kept got %h want 0002", bus.Mem_q);
    end
    bus.RF_s = 1'b1; bus.RF_W_addr = 4'd4; bus.RF_W_en = 1'b1;
    step();
    idle_controls();
    bus.RF_Ra_addr = 4'd4; bus.RF_Rb_addr = 4'd6;
    #1;
    n_checks++;
    if (bus.Ra_data !== 16'h0002 || bus.Rb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_load got r4=%h r6=%h want 0002/0000", bus.Ra_data, bus.Rb_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu();
    test_store_load();
    test_mem_rdw();
    test_rf_rdw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath.md
# datapath

Execution datapath of the simple processor, driven directly by the controller's control outputs (D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0). It contains three parts:
- a 256x16 synchronous data memory;
- a 16x16 register file with two combinational read ports and one write port;
- a 16-bit ALU with eight functions.

It sits beside the controller inside the processor top level. It exposes read-port and ALU values for observation.

## Interface
- DATA_W, 16, datapath word width
- DMEM_AW, 8, data memory address width (depth 2^DMEM_AW)
- RF_AW, 4, register file address width (depth 2^RF_AW)

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset; one clock; reset is asynchronous and active-low
- D_addr  in  DMEM_AW  data memory address
- D_wr  in  1  data memory write enable
- RF_s  in  1  register write source: 0 = ALU result, 1 = data memory read data
- RF_W_addr  in  RF_AW  register write address
- RF_W_en  in  1  register write enable
- RF_Ra_addr  in  RF_AW  read port A address
- RF_Rb_addr  in  RF_AW  read port B address
- Alu_s0  in  3  ALU function select
- Ra_data  out  DATA_W  register file port A value
- Rb_data  out  DATA_W  register file port B value
- ALU_out  out  DATA_W  ALU result
- Mem_q  out  DATA_W  registered data memory read data
- W_data  out  DATA_W  value presented to the register write port

## Operation
- Register file reads are combinational: Ra_data = R[RF_Ra_addr], Rb_data = R[RF_Rb_addr].
- Register write: on a rising Clk with RF_W_en=1, R[RF_W_addr] <= W_data.
- W_data = RF_s ? Mem_q : ALU_out.
- R0 is an ordinary writable register; there is no hardwired zero.
- ALU, with A = Ra_data and B = Rb_data, all arithmetic mod 2^16, no carry or overflow outputs:
  - 000: 0
  - 001: A+B
  - 010: A−B
  - 011: A
  - 100: A^B
  - 101: A|B
  - 110: A&B
  - 111: A+1
- Data memory write: on a rising Clk with D_wr=1, M[D_addr] <= Ra_data.
- Data memory read: every rising Clk, Mem_q <= M[D_addr], regardless of D_wr.
- Read-during-write to the same address returns the old contents on Mem_q. The new value is visible one cycle later.
- The register file has no internal bypass. Reading a register in the same cycle it is written returns the old value; the new value appears after the edge.
- Reset (Rst=0), asynchronous:
  - all registers R0..R15 <= 0;
  - Mem_q <= 0;
  - data memory contents are not cleared.
- While Rst=0, all writes to the register file and data memory are suppressed.
- A write coinciding with a reset assertion is lost.
- After Rst deasserts, the first rising edge performs normal operation.

## Timing
- Outputs after reset: Ra_data=Rb_data=0, Mem_q=0, ALU_out per Alu_s0 on zero operands, W_data per RF_s.
- ALU path: Ra/Rb address → ALU_out → W_data is combinational within one cycle. An ALU op completes in one cycle: the result is in the register file after the edge.
- Load takes two controller cycles:
  - cycle 1: D_addr presented, RF_W_en=0;
  - cycle 2: same D_addr held, RF_s=1, RF_W_en=1;
  - the register is updated at the end of cycle 2.
- Store takes one cycle: D_addr, RF_Ra_addr and D_wr=1 are sampled at the same edge.
- Simultaneous D_wr and RF_W_en are legal and independent.
- X or undriven control inputs are never generated by the controller; behaviour under them is unspecified.

## Test plan
- Reset, then sweep RF_Ra_addr and RF_Rb_addr over 0..15 → Ra_data=Rb_data=0 everywhere; Mem_q=0.
- Build constants:
  - Alu_s0=111, Ra=0, W=1, W_en=1 → R1=1;
  - repeat with Ra=1, W=2 → R2=2;
  - Alu_s0=001, Ra=1, Rb=2, W=3 → R3=3.
  - Then Alu_s0=010 on Ra=1, Rb=3 → ALU_out=0xFFFE (wrap).
  - Check codes 100/101/110 on R2/R3 → 0x0001/0x0003/0x0002.
- Store then load:
  - D_addr=0x80, Ra=3, D_wr=1 for one cycle;
  - hold D_addr=0x80 for one cycle → Mem_q=0x0003;
  - next cycle RF_s=1, W=4, W_en=1 → R4=0x0003.
- Read-during-write: D_addr=0x80, D_wr=1, Ra=2 → Mem_q shows 0x0003 after that edge and 0x0002 one edge later.
- Register read-during-write: W=5, W_en=1, Alu_s0=111, Ra=5 → ALU_out=1 during the cycle (R5 old = 0); R5=1 after the edge.
- Reset mid-operation:
  - assert Rst=0 asynchronously mid-cycle while W_en=1 and D_wr=1 → all registers read 0 immediately and Mem_q=0;
  - after release, loading from 0x80 returns 0x0002 (memory preserved; the write during reset was suppressed).
